// File: rtl/bmf_partition_evaluator_if.sv
// Handshake bundle between the evaluator and the partition under test:
// stimulus pattern out, exact/approximate responses in, metrics out.
interface bmf_partition_evaluator_if #(
  parameter int NUM_IN  = 9,
  parameter int NUM_OUT = 5
);
  logic                       start;
  logic [NUM_IN-1:0]          pattern;
  logic [NUM_OUT-1:0]         exact_out;
  logic [NUM_OUT-1:0]         approx_out;
  logic                       busy;
  logic                       done;
  logic [NUM_IN:0]            err_count;
  logic [NUM_IN+2:0]          hd_sum;
  logic [NUM_IN+NUM_OUT-1:0]  abs_sum;
  logic [NUM_OUT-1:0]         max_abs_err;

  modport master (
    output start, exact_out, approx_out,
    input  pattern, busy, done,
    input  err_count, hd_sum, abs_sum, max_abs_err
  );

  modport slave (
    input  start, exact_out, approx_out,
    output pattern, busy, done,
    output err_count, hd_sum, abs_sum, max_abs_err
  );
endinterface

// File: rtl/bmf_partition_evaluator.sv
// Exhaustive sweep of a partition's input space, accumulating error
// rate, Hamming distance and absolute arithmetic error metrics.
module bmf_partition_evaluator #(
  parameter int NUM_IN  = 9,
  parameter int NUM_OUT = 5
) (
  input logic clk,
  input logic rst,
  bmf_partition_evaluator_if.slave bus
);

  localparam int EW = NUM_IN + 1;
  localparam int HW = NUM_IN + 3;
  localparam int AW = NUM_IN + NUM_OUT;
  localparam int PW = $clog2(NUM_OUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  state_t              state_q;
  logic [NUM_IN-1:0]   pattern_q;
  logic [EW-1:0]       err_q;
  logic [HW-1:0]       hd_q;
  logic [AW-1:0]       abs_q;
  logic [NUM_OUT-1:0]  max_q;
  logic                busy_q;
  logic                done_q;

  logic [NUM_OUT-1:0]  xr;
  logic [NUM_OUT-1:0]  diff;
  logic [PW-1:0]       ham;
  logic                err;
  logic                last;

  logic [EW-1:0]       err_d;
  logic [HW-1:0]       hd_d;
  logic [AW-1:0]       abs_d;
  logic [NUM_OUT-1:0]  max_d;

  // Compare-and-subtract keeps |a-b| within NUM_OUT bits.
  always_comb begin
    xr  = bus.approx_out ^ bus.exact_out;
    err = |xr;
    if (bus.approx_out >= bus.exact_out)
      diff = bus.approx_out - bus.exact_out;
    else
      diff = bus.exact_out - bus.approx_out;
    ham = '0;
    for (int b = 0; b < NUM_OUT; b++)
      ham = ham + PW'(xr[b]);
  end

  always_comb begin
    last  = (pattern_q == {NUM_IN{1'b1}});
    err_d = err_q + EW'(err);
    hd_d  = hd_q + HW'(ham);
    abs_d = abs_q + AW'(diff);
    max_d = (diff > max_q) ? diff : max_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      err_q     <= '0;
      hd_q      <= '0;
      abs_q     <= '0;
      max_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q   <= SWEEP;
            pattern_q <= '0;
            err_q     <= '0;
            hd_q      <= '0;
            abs_q     <= '0;
            max_q     <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        SWEEP: begin
          err_q <= err_d;
          hd_q  <= hd_d;
          abs_q <= abs_d;
          max_q <= max_d;
          // Pattern parks at all-ones once the space is covered.
          if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            pattern_q <= pattern_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pattern     = pattern_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err_count   = err_q;
  assign bus.hd_sum      = hd_q;
  assign bus.abs_sum     = abs_q;
  assign bus.max_abs_err = max_q;

endmodule

// File: tb/tb_bmf_partition_evaluator.sv
// Directed-vector bench: stimulus modes with hand-computed metrics,
// plus start-during-sweep, back-to-back and async reset sequences.
module tb_bmf_partition_evaluator;

  localparam int NI = 9;
  localparam int NO = 5;

  logic clk;
  logic rst;
  int   mode;
  int   n_chk;
  int   n_fail;

  bmf_partition_evaluator_if #(.NUM_IN(NI), .NUM_OUT(NO)) bus ();

  bmf_partition_evaluator #(.NUM_IN(NI), .NUM_OUT(NO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Partition model: exact is the low pattern bits, approx per mode.
  always_comb begin
    bus.exact_out = bus.pattern[NO-1:0];
    case (mode)
      1:       bus.approx_out = '0;
      2:       bus.approx_out = bus.pattern[NO-1:0] ^ 5'b00001;
      3:       bus.approx_out = ~bus.pattern[NO-1:0];
      default: bus.approx_out = bus.pattern[NO-1:0];
    endcase
  end

  typedef struct {
    int mode;
    int err;
    int hd;
    int abs_s;
    int mx;
  } vec_t;

  vec_t tab[4];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_metrics(input string tag, input vec_t v);
    check({tag, " err_count"}, int'(bus.err_count), v.err);
    check({tag, " hd_sum"}, int'(bus.hd_sum), v.hd);
    check({tag, " abs_sum"}, int'(bus.abs_sum), v.abs_s);
    check({tag, " max_abs_err"}, int'(bus.max_abs_err), v.mx);
    check({tag, " pattern"}, int'(bus.pattern), (1 << NI) - 1);
    check({tag, " busy"}, int'(bus.busy), 0);
  endtask

  // Called at a negedge; returns edges from start edge to done=1.
  task automatic sweep(input string tag, input int m, input int hold_at,
                       output int lat);
    int hold;
    mode = m;
    hold = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, " post-start busy"}, int'(bus.busy), 1);
    check({tag, " post-start done"}, int'(bus.done), 0);
    check({tag, " post-start pattern"}, int'(bus.pattern), 0);
    check({tag, " post-start err"}, int'(bus.err_count), 0);
    lat = 0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      lat = c;
      if (bus.done) break;
      if (hold_at >= 0 && int'(bus.pattern) == hold_at) hold = 3;
      if (hold > 0) begin
        bus.start = 1'b1;
        hold--;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int lat;
    bit hit;
    n_chk  = 0;
    n_fail = 0;
    mode   = 0;
    bus.start = 1'b0;

    tab[0] = '{mode: 0, err: 0,   hd: 0,    abs_s: 0,    mx: 0};
    tab[1] = '{mode: 1, err: 496, hd: 1280, abs_s: 7936, mx: 31};
    tab[2] = '{mode: 2, err: 512, hd: 512,  abs_s: 512,  mx: 1};
    tab[3] = '{mode: 3, err: 512, hd: 2560, abs_s: 8192, mx: 31};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset pattern", int'(bus.pattern), 0);
    check("reset err_count", int'(bus.err_count), 0);
    check("reset hd_sum", int'(bus.hd_sum), 0);
    check("reset abs_sum", int'(bus.abs_sum), 0);
    check("reset max_abs_err", int'(bus.max_abs_err), 0);

    for (int i = 0; i < 4; i++) begin
      sweep($sformatf("vec%0d", i), tab[i].mode, -1, lat);
      check($sformatf("vec%0d latency", i), lat, 512);
      check_metrics($sformatf("vec%0d", i), tab[i]);
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d done hold", i), int'(bus.done), 1);
      check($sformatf("vec%0d hold err", i), int'(bus.err_count), tab[i].err);
    end

    sweep("held", 1, 200, lat);
    check("held latency", lat, 512);
    check_metrics("held", tab[1]);

    check("b2b done before", int'(bus.done), 1);
    sweep("b2b", 1, -1, lat);
    check("b2b latency", lat, 512);
    check_metrics("b2b", tab[1]);

    mode = 3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (int'(bus.pattern) == 100) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rst reach pattern 100", int'(hit), 1);
    #2 rst = 1'b1;
    #1;
    check("rst busy", int'(bus.busy), 0);
    check("rst done", int'(bus.done), 0);
    check("rst pattern", int'(bus.pattern), 0);
    check("rst err_count", int'(bus.err_count), 0);
    check("rst hd_sum", int'(bus.hd_sum), 0);
    check("rst abs_sum", int'(bus.abs_sum), 0);
    check("rst max_abs_err", int'(bus.max_abs_err), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sweep("post-rst", 3, -1, lat);
    check("post-rst latency", lat, 512);
    check_metrics("post-rst", tab[3]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bmf_partition_evaluator.md
# bmf_partition_evaluator

Sequential exhaustive-error evaluator for one approximated partition in the BMF flow. A partition's approximate netlist is a compressor feeding latent bits into a decompressor. This block supplies the other end of that path: it drives every input pattern of the partition, then consumes both the exact and the approximate partition outputs. It accumulates error metrics (error rate, Hamming distance, absolute arithmetic error), which are used to accept or reject a factorization degree k.

## Interface
Parameters:
- NUM_IN, 9, partition input width; sweep length is 2^NUM_IN patterns
- NUM_OUT, 5, partition output width; outputs are compared as unsigned integers, bit 0 = LSB

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  begin a sweep; sampled only in IDLE or DONE
- pattern  output  NUM_IN  current stimulus to both the exact and the approximate partition
- exact_out  input  NUM_OUT  exact partition response to pattern (combinational, same cycle)
- approx_out  input  NUM_OUT  approximate partition response to pattern (combinational, same cycle)
- busy  output  1  high while sweeping
- done  output  1  high in DONE; metrics are final and stable
- err_count  output  NUM_IN+1  number of patterns with approx_out != exact_out
- hd_sum  output  NUM_IN+3  sum over patterns of popcount(approx_out ^ exact_out)
- abs_sum  output  NUM_IN+NUM_OUT  sum over patterns of |approx_out - exact_out|
- max_abs_err  output  NUM_OUT  maximum |approx_out - exact_out| seen

## Operation
- States: IDLE, SWEEP, DONE.
  - IDLE --start--> SWEEP
  - SWEEP --(pattern == all-ones, compare done)--> DONE
  - DONE --start--> SWEEP
  - No other transitions.
- Entering SWEEP clears pattern and all four accumulators to 0 in that same edge.
- Each SWEEP cycle compares exact_out and approx_out for the current pattern. On the following edge it adds the results into the accumulators and increments pattern.
- Per-pattern arithmetic:
  - diff = |approx_out - exact_out|, NUM_OUT bits, computed without overflow via unsigned compare-and-subtract.
  - ham = popcount of the XOR, 0..NUM_OUT.
  - err = (XOR != 0).
- Accumulator widths are sized so nothing wraps for a full sweep:
  - err_count max 2^NUM_IN
  - hd_sum max NUM_OUT*2^NUM_IN
  - abs_sum max (2^NUM_OUT-1)*2^NUM_IN
- max_abs_err updates only when the new diff is strictly greater than the stored value.
- pattern does not wrap inside a sweep. In DONE it holds all-ones until the next start.
- start while in SWEEP is ignored: no restart, no accumulator change.
- Metrics hold their values in IDLE and DONE.

## Timing
- Reset values:
  - state IDLE
  - pattern 0
  - busy 0, done 0
  - err_count, hd_sum, abs_sum, max_abs_err all 0
- Reset mid-sweep aborts immediately (asynchronously) to these values. No partial results are retained.
- Edge 0: start=1 sampled. After it, busy=1, pattern=0, accumulators=0.
- SWEEP cycle i (i = 0..2^NUM_IN-1) presents pattern=i. Results for pattern i are included in the accumulators after the edge ending cycle i.
- The edge ending cycle 2^NUM_IN-1 performs the final accumulate and moves to DONE: busy=0, done=1.
- Total latency from the start edge to done=1 is exactly 2^NUM_IN cycles (512 with defaults).
- done stays high until a start is accepted. A start in DONE drops done and raises busy on the same edge.
- busy and done are registered, never both high, and glitch-free.
- exact_out and approx_out are sampled every SWEEP cycle. Their combinational path from pattern must settle within one clk period.

## Test plan
- approx_out = exact_out = pattern[4:0], start pulse -> done exactly 512 cycles after start; err_count=0, hd_sum=0, abs_sum=0, max_abs_err=0.
- exact_out = pattern[4:0], approx_out = 0 -> err_count=496, hd_sum=1280, abs_sum=7936, max_abs_err=31.
- exact_out = pattern[4:0], approx_out = exact_out ^ 5'b00001 -> err_count=512, hd_sum=512, abs_sum=512, max_abs_err=1.
- start held high for 3 cycles during SWEEP at pattern=200 -> sweep continues uninterrupted; final metrics identical to the unperturbed run; done at cycle 512.
- rst asserted asynchronously when pattern=100 -> immediately busy=0, done=0, pattern=0, all metrics 0. A subsequent start gives a full 512-cycle sweep with correct metrics.
- start on the cycle done is high (back-to-back) -> done falls and busy rises on the same edge. Accumulators clear, and the second run's metrics match the first for an identical stimulus.
